// File: rtl/lease_policy_request_sequencer_pkg.sv
// Shared definitions for the lease-policy request sequencer.
//   - clog2: constant ceiling-log2 used to derive line/set/way widths
//   - state_e: sequencer FSM encoding (also exported on the debug state port)
//   - MEM_OP_*: encodings driven on mem_op_o
// Optional statistics are enabled with the LEASE_SEQ_STATS_EN macro.
package lease_policy_request_sequencer_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_LOOKUP     = 4'd1,
    ST_HIT_ISSUE  = 4'd2,
    ST_MISS_ISSUE = 4'd3,
    ST_WAIT_DONE  = 4'd4,
    ST_WRITEBACK  = 4'd5,
    ST_FILL       = 4'd6,
    ST_FOLLOWUP   = 4'd7,
    ST_BYPASS     = 4'd8,
    ST_RESPOND    = 4'd9
  } state_e;

  localparam logic [1:0] MEM_OP_FILL      = 2'b00;
  localparam logic [1:0] MEM_OP_WRITEBACK = 2'b01;
  localparam logic [1:0] MEM_OP_BYPASS    = 2'b10;

endpackage

// File: rtl/lease_policy_request_sequencer_stats_counters.sv
// lease_seq_stats_counters: five 32-bit saturating event counters.
// Ports:
//   clock_i, reset_i (async, active-high)
//   clear_i           synchronous clear, wins over any increment
//   inc_i[4:0]        {random_evict, expired_evict, bypass, miss, hit} pulses
//   *_count_o         counter values
// Only instantiated when LEASE_SEQ_STATS_EN is defined.
module lease_seq_stats_counters (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic [4:0]  inc_i,
  output logic [31:0] hit_count_o,
  output logic [31:0] miss_count_o,
  output logic [31:0] bypass_count_o,
  output logic [31:0] expired_evict_count_o,
  output logic [31:0] random_evict_count_o
);

  logic [31:0] count_q [5];

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < 5; i++) count_q[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (clear_i) begin
          count_q[i] <= '0;
        end else if (inc_i[i] && (count_q[i] != 32'hFFFF_FFFF)) begin
          count_q[i] <= count_q[i] + 32'd1;
        end
      end
    end
  end

  assign hit_count_o           = count_q[0];
  assign miss_count_o          = count_q[1];
  assign bypass_count_o        = count_q[2];
  assign expired_evict_count_o = count_q[3];
  assign random_evict_count_o  = count_q[4];

endmodule

// File: rtl/lease_policy_request_sequencer.sv
// lease_policy_request_sequencer: cache-controller-side initiator for the
// set-associative lease replacement policy. Takes one core request at a time,
// samples the tag lookup, strobes the policy (hit/miss), waits for its
// replacement decision, then performs writeback/fill/bypass on memory and,
// after a swapping miss, issues a follow-up hit so the policy installs the
// saved lease.
// Ports:
//   clock_i, reset_i (async, active-high)
//   core_req_i/core_addr_i/core_done_o    core request side
//   tag_hit_i/tag_addr_i/victim_dirty_i   tag array results
//   hit_o/miss_o/cache_addr_o/llt_search_addr_o   strobes to the policy
//   done_i/swap_i/expired_i/rand_evict_i/addr_i   policy decision
//   mem_req_o/mem_op_o/mem_line_o/mem_ack_i       memory side
//   evict_expired_o/evict_random_o        flags of the last replacement
//   state_o                               debug view of the FSM state
// Optional: LEASE_SEQ_STATS_EN adds stats_clear_i and five event counters.
//
// Handshake: core_req_i is a level held until the one-cycle core_done_o;
// mem_req_o is a level held until the cycle mem_ack_i is sampled high in a
// memory state; acks seen in any other state are ignored.
module lease_policy_request_sequencer
  import lease_policy_request_sequencer_pkg::*;
#(
  parameter int CACHE_BLOCK_CAPACITY = 128,
  parameter int CACHE_SET_SIZE       = 4,
  parameter int BW_ADDR              = 30,
  parameter int BW_OFFSET            = 2,
  localparam int BW_CC               = clog2(CACHE_BLOCK_CAPACITY)
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               core_req_i,
  input  logic [BW_ADDR-1:0] core_addr_i,
  output logic               core_done_o,
  input  logic               tag_hit_i,
  input  logic [BW_CC-1:0]   tag_addr_i,
  input  logic               victim_dirty_i,
  output logic               hit_o,
  output logic               miss_o,
  output logic [BW_CC-1:0]   cache_addr_o,
  output logic [BW_ADDR-1:0] llt_search_addr_o,
  input  logic               done_i,
  input  logic               swap_i,
  input  logic               expired_i,
  input  logic               rand_evict_i,
  input  logic [BW_CC-1:0]   addr_i,
  output logic               mem_req_o,
  output logic [1:0]         mem_op_o,
  output logic [BW_CC-1:0]   mem_line_o,
  input  logic               mem_ack_i,
  output logic               evict_expired_o,
  output logic               evict_random_o,
`ifdef LEASE_SEQ_STATS_EN
  input  logic               stats_clear_i,
  output logic [31:0]        hit_count_o,
  output logic [31:0]        miss_count_o,
  output logic [31:0]        bypass_count_o,
  output logic [31:0]        expired_evict_count_o,
  output logic [31:0]        random_evict_count_o,
`endif
  output logic [3:0]         state_o
);

  localparam int BW_GRP = clog2(CACHE_SET_SIZE);

  state_e state;

  // Set index sits in the upper line-address bits, way bits forced to zero.
  // Shifting the full address keeps this correct even with a single set.
  logic [BW_ADDR-1:0] miss_shift;
  logic [BW_CC-1:0]   miss_line;
  assign miss_shift = (llt_search_addr_o >> BW_OFFSET) << BW_GRP;
  assign miss_line  = miss_shift[BW_CC-1:0];

  assign state_o = state;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state             <= ST_IDLE;
      core_done_o       <= 1'b0;
      hit_o             <= 1'b0;
      miss_o            <= 1'b0;
      cache_addr_o      <= '0;
      llt_search_addr_o <= '0;
      mem_req_o         <= 1'b0;
      mem_op_o          <= MEM_OP_FILL;
      mem_line_o        <= '0;
      evict_expired_o   <= 1'b0;
      evict_random_o    <= 1'b0;
    end else begin
      // Strobes default low so each lasts exactly one cycle.
      core_done_o <= 1'b0;
      hit_o       <= 1'b0;
      miss_o      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (core_req_i) begin
            llt_search_addr_o <= core_addr_i;
            state             <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (tag_hit_i) begin
            cache_addr_o <= tag_addr_i;
            hit_o        <= 1'b1;
            state        <= ST_HIT_ISSUE;
          end else begin
            cache_addr_o <= miss_line;
            miss_o       <= 1'b1;
            state        <= ST_MISS_ISSUE;
          end
        end
        ST_HIT_ISSUE: begin
          core_done_o <= 1'b1;
          state       <= ST_RESPOND;
        end
        ST_MISS_ISSUE: begin
          // done_i is deliberately not looked at here: anything the policy
          // shows during the miss strobe cycle is stale.
          state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (done_i) begin
            mem_req_o <= 1'b1;
            if (swap_i) begin
              mem_line_o      <= addr_i;
              evict_expired_o <= expired_i;
              evict_random_o  <= rand_evict_i;
              if (victim_dirty_i) begin
                mem_op_o <= MEM_OP_WRITEBACK;
                state    <= ST_WRITEBACK;
              end else begin
                mem_op_o <= MEM_OP_FILL;
                state    <= ST_FILL;
              end
            end else begin
              mem_op_o <= MEM_OP_BYPASS;
              state    <= ST_BYPASS;
            end
          end
        end
        ST_WRITEBACK: begin
          // Request stays high; only the operation changes to fill.
          if (mem_ack_i) begin
            mem_op_o <= MEM_OP_FILL;
            state    <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (mem_ack_i) begin
            mem_req_o    <= 1'b0;
            hit_o        <= 1'b1;
            cache_addr_o <= mem_line_o;
            state        <= ST_FOLLOWUP;
          end
        end
        ST_FOLLOWUP: begin
          core_done_o <= 1'b1;
          state       <= ST_RESPOND;
        end
        ST_BYPASS: begin
          if (mem_ack_i) begin
            mem_req_o   <= 1'b0;
            core_done_o <= 1'b1;
            state       <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef LEASE_SEQ_STATS_EN
  // Event pulses mirror the FSM transitions taken on this clock edge.
  logic [4:0] stats_inc;
  always_comb begin
    stats_inc    = '0;
    stats_inc[0] = (state == ST_LOOKUP) && tag_hit_i;
    stats_inc[1] = (state == ST_LOOKUP) && !tag_hit_i;
    stats_inc[2] = (state == ST_WAIT_DONE) && done_i && !swap_i;
    stats_inc[3] = (state == ST_WAIT_DONE) && done_i && swap_i && expired_i;
    stats_inc[4] = (state == ST_WAIT_DONE) && done_i && swap_i && rand_evict_i;
  end

  lease_seq_stats_counters u_stats (
    .clock_i               (clock_i),
    .reset_i               (reset_i),
    .clear_i               (stats_clear_i),
    .inc_i                 (stats_inc),
    .hit_count_o           (hit_count_o),
    .miss_count_o          (miss_count_o),
    .bypass_count_o        (bypass_count_o),
    .expired_evict_count_o (expired_evict_count_o),
    .random_evict_count_o  (random_evict_count_o)
  );
`endif

endmodule

// File: tb/tb_lease_policy_request_sequencer.sv
// Directed bench for lease_policy_request_sequencer (default build).
// Inputs change 1 time unit after the rising edge; outputs are checked at
// that point, i.e. they show the registered values of the new cycle.
module tb_lease_policy_request_sequencer;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        core_req_i = 1'b0;
  logic [29:0] core_addr_i = '0;
  logic        core_done_o;
  logic        tag_hit_i = 1'b0;
  logic [6:0]  tag_addr_i = '0;
  logic        victim_dirty_i = 1'b0;
  logic        hit_o;
  logic        miss_o;
  logic [6:0]  cache_addr_o;
  logic [29:0] llt_search_addr_o;
  logic        done_i = 1'b0;
  logic        swap_i = 1'b0;
  logic        expired_i = 1'b0;
  logic        rand_evict_i = 1'b0;
  logic [6:0]  addr_i = '0;
  logic        mem_req_o;
  logic [1:0]  mem_op_o;
  logic [6:0]  mem_line_o;
  logic        mem_ack_i = 1'b0;
  logic        evict_expired_o;
  logic        evict_random_o;
  logic [3:0]  state_o;

  int checks = 0;
  int failures = 0;

  // ---------------- clock / reset
  always #5 clock_i = ~clock_i;

  lease_policy_request_sequencer dut (
    .clock_i           (clock_i),
    .reset_i           (reset_i),
    .core_req_i        (core_req_i),
    .core_addr_i       (core_addr_i),
    .core_done_o       (core_done_o),
    .tag_hit_i         (tag_hit_i),
    .tag_addr_i        (tag_addr_i),
    .victim_dirty_i    (victim_dirty_i),
    .hit_o             (hit_o),
    .miss_o            (miss_o),
    .cache_addr_o      (cache_addr_o),
    .llt_search_addr_o (llt_search_addr_o),
    .done_i            (done_i),
    .swap_i            (swap_i),
    .expired_i         (expired_i),
    .rand_evict_i      (rand_evict_i),
    .addr_i            (addr_i),
    .mem_req_o         (mem_req_o),
    .mem_op_o          (mem_op_o),
    .mem_line_o        (mem_line_o),
    .mem_ack_i         (mem_ack_i),
    .evict_expired_o   (evict_expired_o),
    .evict_random_o    (evict_random_o),
    .state_o           (state_o)
  );

  // ---------------- driver tasks
  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Strobes/state in one shot: {core_done, hit, miss, mem_req}
  task automatic chk_ctl(input string tag, input logic [3:0] st, input logic [3:0] strobes);
    chk({tag, "_state"}, 64'(state_o), 64'(st));
    chk({tag, "_strobes"}, 64'({core_done_o, hit_o, miss_o, mem_req_o}), 64'(strobes));
  endtask

  initial begin
    // ---------------- reset
    tick();
    tick();
    chk_ctl("reset", 4'd0, 4'b0000);
    chk("reset_outs", 64'({cache_addr_o, llt_search_addr_o, mem_op_o, mem_line_o,
                           evict_expired_o, evict_random_o}), 64'd0);
    reset_i = 1'b0;
    tick();

    // ---------------- hit path: request at cycle 0
    core_req_i = 1'b1; core_addr_i = 30'h100;
    tick();                                   // cycle 1
    chk_ctl("hit_c1", 4'd1, 4'b0000);
    chk("hit_llt", 64'(llt_search_addr_o), 64'h100);
    tag_hit_i = 1'b1; tag_addr_i = 7'h15;
    tick();                                   // cycle 2
    chk_ctl("hit_c2", 4'd2, 4'b0100);
    chk("hit_caddr", 64'(cache_addr_o), 64'h15);
    tag_hit_i = 1'b0;
    tick();                                   // cycle 3
    chk_ctl("hit_c3", 4'd9, 4'b1000);
    core_req_i = 1'b0;
    tick();
    chk_ctl("hit_c4", 4'd0, 4'b0000);

    // ---------------- clean swap miss, addr 0x1237 -> set 0xD -> line 0x34
    core_req_i = 1'b1; core_addr_i = 30'h1237;
    tick();
    tick();                                   // cycle 2
    chk_ctl("cmiss_c2", 4'd3, 4'b0010);
    chk("cmiss_caddr", 64'(cache_addr_o), 64'h34);
    tick();                                   // cycle 3, WAIT_DONE
    chk_ctl("cmiss_c3", 4'd4, 4'b0000);
    done_i = 1'b1; swap_i = 1'b1; addr_i = 7'h2A; victim_dirty_i = 1'b0;
    tick();                                   // cycle 4, FILL
    chk_ctl("cmiss_c4", 4'd6, 4'b0001);
    chk("cmiss_op", 64'(mem_op_o), 64'd0);
    chk("cmiss_line", 64'(mem_line_o), 64'h2A);
    done_i = 1'b0; swap_i = 1'b0; addr_i = 7'h00;
    tick();                                   // fill still pending
    chk_ctl("cmiss_c5", 4'd6, 4'b0001);
    mem_ack_i = 1'b1;
    tick();                                   // FOLLOWUP
    mem_ack_i = 1'b0;
    chk_ctl("cmiss_fup", 4'd7, 4'b0100);
    chk("cmiss_fup_addr", 64'(cache_addr_o), 64'h2A);
    tick();
    chk_ctl("cmiss_resp", 4'd9, 4'b1000);
    core_req_i = 1'b0;
    tick();

    // ---------------- dirty victim, expired; addr 0x40 -> line 0x40
    core_req_i = 1'b1; core_addr_i = 30'h40;
    tick();
    tick();
    chk("dmiss_caddr", 64'(cache_addr_o), 64'h40);
    tick();
    done_i = 1'b1; swap_i = 1'b1; addr_i = 7'h2A; victim_dirty_i = 1'b1; expired_i = 1'b1;
    tick();                                   // WRITEBACK
    done_i = 1'b0; swap_i = 1'b0; victim_dirty_i = 1'b0; expired_i = 1'b0;
    chk_ctl("dmiss_wb", 4'd5, 4'b0001);
    chk("dmiss_wb_op", 64'(mem_op_o), 64'd1);
    chk("dmiss_wb_line", 64'(mem_line_o), 64'h2A);
    chk("dmiss_flags", 64'({evict_expired_o, evict_random_o}), 64'b10);
    mem_ack_i = 1'b1;
    tick();                                   // FILL
    mem_ack_i = 1'b0;
    chk_ctl("dmiss_fill", 4'd6, 4'b0001);
    chk("dmiss_fill_op", 64'(mem_op_o), 64'd0);
    tick();
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    chk_ctl("dmiss_fup", 4'd7, 4'b0100);
    tick();
    chk_ctl("dmiss_resp", 4'd9, 4'b1000);
    core_req_i = 1'b0;
    tick();

    // ---------------- bypass, ack in first bypass cycle -> done at cycle 5
    core_req_i = 1'b1; core_addr_i = 30'h0;
    tick();                                   // 1
    tick();                                   // 2
    chk("byp_caddr", 64'(cache_addr_o), 64'h0);
    tick();                                   // 3
    done_i = 1'b1; swap_i = 1'b0;
    tick();                                   // 4
    done_i = 1'b0;
    chk_ctl("byp_c4", 4'd8, 4'b0001);
    chk("byp_op", 64'(mem_op_o), 64'd2);
    chk("byp_flags_held", 64'({evict_expired_o, evict_random_o}), 64'b10);
    mem_ack_i = 1'b1;
    tick();                                   // 5
    mem_ack_i = 1'b0;
    chk_ctl("byp_c5", 4'd9, 4'b1000);
    core_req_i = 1'b0;
    tick();
    chk_ctl("byp_c6", 4'd0, 4'b0000);

    // ---------------- delayed done, stray ack, random eviction; addr 0x7C
    core_req_i = 1'b1; core_addr_i = 30'h7C;
    tick();
    tick();
    chk("dly_caddr", 64'(cache_addr_o), 64'h7C);
    tick();                                   // WAIT_DONE, 1st cycle low
    mem_ack_i = 1'b1;                         // ignored outside memory states
    tick();
    mem_ack_i = 1'b0;
    chk_ctl("dly_w2", 4'd4, 4'b0000);
    tick();
    chk_ctl("dly_w3", 4'd4, 4'b0000);
    tick();
    done_i = 1'b1; swap_i = 1'b1; rand_evict_i = 1'b1; addr_i = 7'h11;
    tick();                                   // FILL
    done_i = 1'b0; swap_i = 1'b0; rand_evict_i = 1'b0;
    chk_ctl("dly_fill", 4'd6, 4'b0001);
    chk("dly_flags", 64'({evict_expired_o, evict_random_o}), 64'b01);
    chk("dly_line", 64'(mem_line_o), 64'h11);

    // ---------------- async reset in FILL
    #2 reset_i = 1'b1;
    #1;
    chk_ctl("rst_fill", 4'd0, 4'b0000);
    chk("rst_flags", 64'({evict_expired_o, evict_random_o, mem_line_o}), 64'd0);
    core_req_i = 1'b0;
    tick();
    reset_i = 1'b0;
    tick();

    // ---------------- fresh hit then back-to-back hit
    core_req_i = 1'b1; core_addr_i = 30'h3FF;
    tick();
    tag_hit_i = 1'b1; tag_addr_i = 7'h7F;
    tick();
    chk_ctl("post_c2", 4'd2, 4'b0100);
    chk("post_caddr", 64'(cache_addr_o), 64'h7F);
    tag_hit_i = 1'b0;
    tick();
    chk_ctl("post_c3", 4'd9, 4'b1000);
    core_addr_i = 30'h2AB_CDEF;               // new request held through RESPOND
    tick();
    chk_ctl("b2b_idle", 4'd0, 4'b0000);
    tick();
    chk_ctl("b2b_lookup", 4'd1, 4'b0000);
    chk("b2b_llt", 64'(llt_search_addr_o), 64'h2AB_CDEF);
    tag_hit_i = 1'b1; tag_addr_i = 7'h01;
    tick();
    tag_hit_i = 1'b0;
    chk_ctl("b2b_hit", 4'd2, 4'b0100);
    tick();
    chk_ctl("b2b_done", 4'd9, 4'b1000);
    core_req_i = 1'b0;
    tick();

    // ---------------- report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
